snoop_bus_responder: RTL and testbench
======================================

SNOOP_BUS_RESPONDER -- requirements
Module: snoop_bus_responder

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 32, address width; OFFSET_W, 6, line-offset bits cleared on outgoing addresses; SNOOP_TO, 15, snoop timeout in cycles; CNT_W, 16, statistics counter width.
REQ-002 One clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  cache bus-operation request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_op  input  2  00 READ, 01 WRITE, 10 INVALIDATE, 11 RFO.
REQ-008 req_addr  input  ADDR_W  request address.
REQ-009 snoop_valid  output  1  snoop broadcast active.
REQ-010 snoop_op  output  2  latched op being snooped.
REQ-011 snoop_addr  output  ADDR_W  line-aligned snoop address.
REQ-012 snoop_rsp_valid  input  1  snoop result present.
REQ-013 snoop_rsp  input  2  00 NoHIT, 01 HIT, 10 HITM, 11 reserved (treated as NoHIT).
REQ-014 mem_req  output  1  memory access request.
REQ-015 mem_we  output  1  1 = write, 0 = read.
REQ-016 mem_addr  output  ADDR_W  line-aligned memory address.
REQ-017 mem_ack  input  1  memory access complete.
REQ-018 rsp_valid  output  1  one-cycle completion pulse to cache.
REQ-019 rsp_result  output  2  final snoop result for the transaction.
REQ-020 rsp_timeout  output  1  snoop phase ended by timeout.
REQ-021 cnt_read, cnt_write, cnt_inval, cnt_rfo  output  CNT_W each  accepted-request counters.

Function
REQ-022 FSM states SHALL be IDLE, SNOOP, MEM, RESP; req_ready SHALL be 1 only in IDLE.
REQ-023 IDLE: on req_valid&&req_ready, latch op and addr with bits [OFFSET_W-1:0] zeroed; next state MEM if op=WRITE, else SNOOP.
REQ-024 SNOOP: snoop_valid=1 with snoop_op/snoop_addr held stable; timer clears on entry and increments each SNOOP cycle.
REQ-025 SNOOP exit on snoop_rsp_valid: latch result (11 mapped to 00); READ/RFO with result≠HITM go to MEM; otherwise go to RESP.
REQ-026 SNOOP timeout: if timer reaches SNOOP_TO-1 without snoop_rsp_valid, result=NoHIT, timeout flag set, exit as for NoHIT; snoop_rsp_valid in that same cycle takes precedence and clears the timeout flag.
REQ-027 MEM: mem_req=1, mem_we=(op==WRITE), mem_addr=latched address, all held until mem_ack; on mem_ack go to RESP; mem_ack outside MEM is ignored.
REQ-028 RESP: rsp_valid=1 for exactly one cycle with rsp_result and rsp_timeout valid; then IDLE.
REQ-029 WRITE SHALL report rsp_result=NoHIT, rsp_timeout=0.
REQ-030 Counters SHALL increment by op on request acceptance and saturate at all-ones (no wrap).
REQ-031 Minimum latency, accept to rsp_valid: READ/RFO = 3 cycles with snoop rsp and mem_ack each in first cycle; INVALIDATE or HITM = 2 cycles; WRITE = 2 cycles.
REQ-032 snoop_valid, mem_req, rsp_valid SHALL be registered outputs.

Reset
REQ-033 rst_n low SHALL asynchronously force IDLE and clear snoop_valid, mem_req, mem_we, rsp_valid, rsp_timeout, rsp_result=00, snoop/mem addresses and ops to 0, all counters to 0; req_ready=1 after release.
REQ-034 Reset mid-transaction SHALL abandon it with no rsp_valid pulse.

Verification
REQ-035 READ 0x0000_1234, snoop_rsp=HIT after 2 cycles, mem_ack after 1 -> snoop_addr=0x0000_1200, mem_we=0, rsp_result=01, cnt_read=1.
REQ-036 RFO, snoop_rsp=HITM -> no mem_req asserted, rsp_result=10 two cycles after accept.
REQ-037 INVALIDATE, no snoop response -> rsp_timeout=1, rsp_result=00 after SNOOP_TO snoop cycles; snoop_rsp_valid in the final timer cycle -> rsp_timeout=0.
REQ-038 WRITE 0xFFFF_FFC5 -> no snoop_valid, mem_we=1, mem_addr=0xFFFF_FFC0, cnt_write=1.
REQ-039 Force cnt_read to 0xFFFF, issue READ -> stays 0xFFFF; assert rst_n=0 during MEM -> outputs at reset values, no rsp_valid.

Source files
------------

// File: rtl/snoop_bus_responder.sv
// Bus-operation responder: snoops READ/INVALIDATE/RFO, runs memory access when needed, pulses completion.
// Latency 2-3 cycles minimum accept-to-rsp_valid; req_ready is held low until the transaction completes.
module snoop_bus_responder #(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int SNOOP_TO = 15,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              snoop_valid,
    output logic [1:0]        snoop_op,
    output logic [ADDR_W-1:0] snoop_addr,
    input  logic              snoop_rsp_valid,
    input  logic [1:0]        snoop_rsp,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              rsp_valid,
    output logic [1:0]        rsp_result,
    output logic              rsp_timeout,
    output logic [CNT_W-1:0]  cnt_read,
    output logic [CNT_W-1:0]  cnt_write,
    output logic [CNT_W-1:0]  cnt_inval,
    output logic [CNT_W-1:0]  cnt_rfo
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SNOOP = 2'd1,
        S_MEM   = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_INVAL  = 2'b10;
    localparam logic [1:0] OP_RFO    = 2'b11;
    localparam logic [1:0] RSP_NOHIT = 2'b00;
    localparam logic [1:0] RSP_HITM  = 2'b10;

    localparam int TMR_W = (SNOOP_TO > 1) ? $clog2(SNOOP_TO) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(SNOOP_TO - 1);
    localparam logic [ADDR_W-1:0] OFF_MASK = {{(ADDR_W-OFFSET_W){1'b0}}, {OFFSET_W{1'b1}}};

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [1:0]        result_q, result_d;
    logic              timeout_q, timeout_d;
    logic              snoop_valid_q, mem_req_q, mem_we_q, rsp_valid_q;
    logic [CNT_W-1:0]  cnt_read_q, cnt_write_q, cnt_inval_q, cnt_rfo_q;

    logic [1:0] snp_rsp_m;
    logic       is_rd_rfo;
    logic       accept;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept    = req_valid && (state_q == S_IDLE);
    assign snp_rsp_m = (snoop_rsp == 2'b11) ? RSP_NOHIT : snoop_rsp;
    assign is_rd_rfo = (op_q == OP_READ) || (op_q == OP_RFO);

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        timer_d   = timer_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d      = req_op;
                    addr_d    = req_addr & ~OFF_MASK;
                    timer_d   = '0;
                    result_d  = RSP_NOHIT;
                    timeout_d = 1'b0;
                    state_d   = (req_op == OP_WRITE) ? S_MEM : S_SNOOP;
                end
            end
            S_SNOOP: begin
                // A response arriving on the last timer cycle beats the timeout.
                if (snoop_rsp_valid) begin
                    result_d  = snp_rsp_m;
                    timeout_d = 1'b0;
                    state_d   = (is_rd_rfo && (snp_rsp_m != RSP_HITM)) ? S_MEM : S_RESP;
                end else if (timer_q == TMR_LAST) begin
                    result_d  = RSP_NOHIT;
                    timeout_d = 1'b1;
                    state_d   = is_rd_rfo ? S_MEM : S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_MEM: begin
                if (mem_ack) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            op_q          <= 2'b00;
            addr_q        <= '0;
            timer_q       <= '0;
            result_q      <= RSP_NOHIT;
            timeout_q     <= 1'b0;
            snoop_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            rsp_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            timer_q       <= timer_d;
            result_q      <= result_d;
            timeout_q     <= timeout_d;
            snoop_valid_q <= (state_d == S_SNOOP);
            mem_req_q     <= (state_d == S_MEM);
            mem_we_q      <= (state_d == S_MEM) && (op_d == OP_WRITE);
            rsp_valid_q   <= (state_d == S_RESP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_read_q  <= '0;
            cnt_write_q <= '0;
            cnt_inval_q <= '0;
            cnt_rfo_q   <= '0;
        end else if (accept) begin
            case (req_op)
                OP_READ:  cnt_read_q  <= sat_inc(cnt_read_q);
                OP_WRITE: cnt_write_q <= sat_inc(cnt_write_q);
                OP_INVAL: cnt_inval_q <= sat_inc(cnt_inval_q);
                default:  cnt_rfo_q   <= sat_inc(cnt_rfo_q);
            endcase
        end
    end

    assign req_ready   = (state_q == S_IDLE);
    assign snoop_valid = snoop_valid_q;
    assign snoop_op    = op_q;
    assign snoop_addr  = addr_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = result_q;
    assign rsp_timeout = timeout_q;
    assign cnt_read    = cnt_read_q;
    assign cnt_write   = cnt_write_q;
    assign cnt_inval   = cnt_inval_q;
    assign cnt_rfo     = cnt_rfo_q;

endmodule

// File: tb/tb_snoop_bus_responder.sv
// Randomized bench for snoop_bus_responder against a per-transaction outcome model.
// Narrow counters are used so saturation is reachable in a short run.
module tb_snoop_bus_responder;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int SNOOP_TO = 15;
    localparam int CNT_W    = 5;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              snoop_valid;
    logic [1:0]        snoop_op;
    logic [ADDR_W-1:0] snoop_addr;
    logic              snoop_rsp_valid;
    logic [1:0]        snoop_rsp;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic              rsp_valid;
    logic [1:0]        rsp_result;
    logic              rsp_timeout;
    logic [CNT_W-1:0]  cnt_read, cnt_write, cnt_inval, cnt_rfo;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt [4];

    snoop_bus_responder #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .SNOOP_TO(SNOOP_TO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
        .snoop_rsp_valid(snoop_rsp_valid), .snoop_rsp(snoop_rsp),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_inval(cnt_inval), .cnt_rfo(cnt_rfo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_counters();
        chk("cnt_read",  64'(cnt_read),  64'(exp_cnt[0]));
        chk("cnt_write", 64'(cnt_write), 64'(exp_cnt[1]));
        chk("cnt_inval", 64'(cnt_inval), 64'(exp_cnt[2]));
        chk("cnt_rfo",   64'(cnt_rfo),   64'(exp_cnt[3]));
    endtask

    // d: snoop cycle index (0-based) carrying the response, >= SNOOP_TO means never.
    // ackd: memory cycle index (0-based) carrying mem_ack.
    task automatic run_txn(input logic [1:0] op, input logic [31:0] addr, input int d,
                           input logic [1:0] rsp, input int ackd);
        logic [31:0] e_addr;
        logic [1:0]  e_res;
        logic        e_to;
        int          e_s, e_m, sc, mc, cyc;
        bit          got;
        e_addr = addr & 32'hFFFF_FFC0;
        if (op == 2'b01) begin
            e_s = 0; e_res = 2'b00; e_to = 1'b0; e_m = ackd + 1;
        end else begin
            if (d < SNOOP_TO) begin
                e_s = d + 1; e_res = (rsp == 2'b11) ? 2'b00 : rsp; e_to = 1'b0;
            end else begin
                e_s = SNOOP_TO; e_res = 2'b00; e_to = 1'b1;
            end
            e_m = ((op == 2'b00 || op == 2'b11) && e_res != 2'b10) ? ackd + 1 : 0;
        end
        chk("ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        @(negedge clk);
        if (exp_cnt[op] < CNT_MAX) exp_cnt[op]++;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = $urandom;
        sc = 0; mc = 0; cyc = 0; got = 0;
        while (!got && cyc < 300) begin
            cyc++;
            snoop_rsp_valid = 1'b0;
            snoop_rsp       = 2'($urandom);
            mem_ack         = ($urandom_range(0, 3) == 0);
            if (snoop_valid) begin
                chk("snoop_addr", 64'(snoop_addr), 64'(e_addr));
                chk("snoop_op",   64'(snoop_op),   64'(op));
                if (sc == d) begin
                    snoop_rsp_valid = 1'b1;
                    snoop_rsp       = rsp;
                end
                sc++;
            end
            if (mem_req) begin
                chk("mem_addr", 64'(mem_addr), 64'(e_addr));
                chk("mem_we",   64'(mem_we),   64'(op == 2'b01));
                mem_ack = (mc == ackd);
                mc++;
            end
            if (rsp_valid) begin
                got = 1;
                chk("latency",     64'(cyc),         64'(e_s + e_m + 1));
                chk("snoop_cycles", 64'(sc),         64'(e_s));
                chk("mem_cycles",  64'(mc),          64'(e_m));
                chk("rsp_result",  64'(rsp_result),  64'(e_res));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e_to));
            end else begin
                chk("ready_busy", 64'(req_ready), 64'd0);
            end
            @(negedge clk);
        end
        if (!got) chk("rsp_wait_expired", 64'd0, 64'd1);
        snoop_rsp_valid = 1'b0;
        mem_ack         = 1'b0;
        chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
        chk("ready_after",   64'(req_ready), 64'd1);
        chk_counters();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"},   64'(req_ready),   64'd1);
        chk({tag, "_snoop_v"}, 64'(snoop_valid), 64'd0);
        chk({tag, "_snoop_op"}, 64'(snoop_op),   64'd0);
        chk({tag, "_snoop_a"}, 64'(snoop_addr),  64'd0);
        chk({tag, "_mem_req"}, 64'(mem_req),     64'd0);
        chk({tag, "_mem_we"},  64'(mem_we),      64'd0);
        chk({tag, "_mem_a"},   64'(mem_addr),    64'd0);
        chk({tag, "_rsp_v"},   64'(rsp_valid),   64'd0);
        chk({tag, "_rsp_r"},   64'(rsp_result),  64'd0);
        chk({tag, "_rsp_to"},  64'(rsp_timeout), 64'd0);
        chk_counters();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_op = 2'b00; req_addr = '0;
        snoop_rsp_valid = 1'b0; snoop_rsp = 2'b00; mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(2'b00, 32'h0000_1234, 1, 2'b01, 1);
        run_txn(2'b11, 32'h0ABC_DE7F, 0, 2'b10, 0);
        run_txn(2'b10, 32'h1234_5678, 99, 2'b00, 0);
        run_txn(2'b10, 32'h1234_5678, SNOOP_TO - 1, 2'b01, 0);
        run_txn(2'b01, 32'hFFFF_FFC5, 0, 2'b00, 0);
        run_txn(2'b00, 32'h0000_0040, 0, 2'b11, 0);
        run_txn(2'b11, 32'h8000_0001, 99, 2'b00, 2);

        for (int t = 0; t < 150; t++) begin
            run_txn(2'($urandom_range(0, 3)), $urandom, $urandom_range(0, SNOOP_TO + 2),
                    2'($urandom_range(0, 3)), $urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int t = 0; t < CNT_MAX + 3; t++) run_txn(2'b00, $urandom, 0, 2'b01, 0);
        chk("cnt_read_saturated", 64'(cnt_read), 64'(CNT_MAX));

        // Abandon a READ while it waits in the memory phase.
        req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h5555_5555;
        @(negedge clk);
        req_valid = 1'b0;
        snoop_rsp_valid = 1'b1; snoop_rsp = 2'b00;
        @(negedge clk);
        snoop_rsp_valid = 1'b0;
        chk("mid_txn_mem_req", 64'(mem_req), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
        chk_reset_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
        end
        chk("ready_after_rst", 64'(req_ready), 64'd1);
        run_txn(2'b11, 32'h0000_2000, 2, 2'b01, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
